// File: rtl/nand_fn_exerciser.sv
// Exhaustive stimulus/response checker for a 4-input, 1-output gate-level function block.
// It walks all 16 input vectors, lets each settle, samples w and reports mismatches against a golden table.
module nand_fn_exerciser #(
  parameter logic [15:0] EXPECTED = 16'h1BBB,
  parameter int unsigned SETTLE   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  output logic       dut_d,
  input  logic       dut_w,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [4:0] err_q, err_d;
  logic       fvalid_q, fvalid_d;
  logic [3:0] fvec_q, fvec_d;
  logic       mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_WAIT;
      S_WAIT:         if (cnt_q == 8'd0) state_d = S_CHECK;
      S_CHECK:        state_d = (vec_q == 4'hF) ? S_DONE : S_WAIT;
      default:        state_d = S_IDLE;
    endcase
  end

  // dut_w goes straight into the compare: SETTLE must cover the gate's worst-case delay.
  assign mismatch = (dut_w != EXPECTED[vec_q]);

  always_comb begin
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d    = '0;
          cnt_d    = CNT_INIT;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          fvalid_d = 1'b0;
          fvec_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 5'd1;
          if (!fvalid_q) begin
            fvec_d   = vec_q;
            fvalid_d = 1'b1;
          end
        end
        // Pass uses the count including this final vector's result.
        if (vec_q == 4'hF) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_d == 5'd0);
        end else begin
          vec_d = vec_q + 4'd1;
          cnt_d = CNT_INIT;
        end
      end
      default: ;
    endcase
  end

  assign dut_a      = vec_q[3];
  assign dut_b      = vec_q[2];
  assign dut_c      = vec_q[1];
  assign dut_d      = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fvalid_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_nand_fn_exerciser.sv
// Bench for nand_fn_exerciser: a delayed behavioural gate model answers the exerciser,
// expected run results are queued at start and checked by a monitor when done rises.
module tb_nand_fn_exerciser;

  localparam int M_GOOD = 0, M_TIE0 = 1, M_TIE1 = 2, M_INV = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dut_a, dut_b, dut_c, dut_d;
  logic       dut_w;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic       fail_valid;
  logic [3:0] fail_vec;

  nand_fn_exerciser #(.EXPECTED(16'h1BBB), .SETTLE(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_d(dut_d),
    .dut_w(dut_w), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    int err;
    int fv;
    int fvec;
    int pass;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         mode = M_GOOD;
  int         run_no = 0;
  logic [15:0] golden = 16'h1BBB;

  function automatic logic gate_fn(int m, logic [3:0] v);
    logic a, b, c, d, w;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    w = !((c | d) & ((a & b) | !d));
    case (m)
      M_TIE0:  return 1'b0;
      M_TIE1:  return 1'b1;
      M_INV:   return !w;
      default: return w;
    endcase
  endfunction

  function automatic exp_t predict(int m);
    exp_t e;
    e.err = 0; e.fv = 0; e.fvec = 0;
    for (int i = 0; i < 16; i++) begin
      if (gate_fn(m, 4'(i)) != golden[i]) begin
        if (e.err == 0) begin
          e.fv = 1;
          e.fvec = i;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  // Gate model with a two-cycle propagation delay, well inside the settle window.
  logic w_d1 = 1'b0, w_d2 = 1'b0;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    w_d1 <= gate_fn(mode, {dut_a, dut_b, dut_c, dut_d});
    w_d2 <= w_d1;
  end
  assign dut_w = w_d2;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: traces the driven vectors during a run and scores results when done rises.
  logic busy_prev = 1'b0, done_prev = 1'b0;
  int   start_cyc = 0;
  int   trace[$];
  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      start_cyc = cyc;
      trace.delete();
    end
    if (busy) trace.push_back(int'({dut_a, dut_b, dut_c, dut_d}));
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        int ok;
        e = sb.pop_front();
        ok = (trace.size() == 80) ? 1 : 0;
        foreach (trace[k]) if (trace[k] != k / 5) ok = 0;
        $display("run %0d: err=%0d fv=%0d fvec=%0d pass=%0d latency=%0d (exp err=%0d fvec=%0d pass=%0d)",
                 run_no, err_count, fail_valid, fail_vec, pass, cyc - start_cyc, e.err, e.fvec, e.pass);
        chk("err_count", int'(err_count), e.err);
        chk("fail_valid", int'(fail_valid), e.fv);
        if (e.fv != 0) chk("fail_vec", int'(fail_vec), e.fvec);
        chk("pass", int'(pass), e.pass);
        chk("busy_at_done", int'(busy), 0);
        chk("latency", cyc - start_cyc, 80);
        chk("vec_trace", ok, 1);
        chk("final_vec", int'({dut_a, dut_b, dut_c, dut_d}), 15);
        run_no++;
      end
    end
    busy_prev = busy;
    done_prev = done;
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_fv"}, int'(fail_valid), 0);
    chk({tag, "_fvec"}, int'(fail_vec), 0);
    chk({tag, "_vec"}, int'({dut_a, dut_b, dut_c, dut_d}), 0);
  endtask

  task automatic run(int m, int spurious);
    mode = m;
    sb.push_back(predict(m));
    pulse_start();
    if (spurious >= 0) begin
      repeat (spurious) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(200);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    run(M_GOOD, -1);
    run(M_TIE0, -1);
    run(M_TIE1, -1);
    run(M_INV, -1);

    // Restart straight from DONE: results clear on the start edge, run repeats.
    sb.push_back(predict(M_INV));
    pulse_start();
    chk("clear_err", int'(err_count), 0);
    chk("clear_fv", int'(fail_valid), 0);
    chk("clear_done", int'(done), 0);
    chk("clear_busy", int'(busy), 1);
    wait_done(200);

    // Start re-pulsed while vector 5 is driven is ignored.
    run(M_GOOD, 26);

    // Asynchronous reset in vector 7 aborts the run mid-cycle.
    mode = M_GOOD;
    pulse_start();
    repeat (36) @(negedge clk);
    chk("vec7_before_rst", int'({dut_a, dut_b, dut_c, dut_d}), 7);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    check_all_zero("after_abort");
    run(M_GOOD, -1);

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      run(int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 70)) : -1);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
